vga_sync_gen: RTL and testbench

Generates the 640x480 @ 60 Hz VGA raster for the display path. It divides the board clock down to the pixel rate, runs the horizontal and vertical position counters, and presents the current column/row to the pattern generators. It then takes their combinational colour back, blanks it outside the visible area, and drives the monitor pins (hsync, vsync, rgb) from registers aligned to one another.

---
 rtl/vga_sync_if.sv | 19 +
 rtl/vga_sync_gen.sv | 75 +++++++
 tb/tb_vga_sync_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// vga_sync_if: raster position, colour return path and monitor pins of the VGA sync generator.
interface vga_sync_if;
    logic [2:0] rgb_i;
    logic [9:0] column_o;
    logic [9:0] row_o;
    logic       video_on_o;
    logic       frame_o;
    logic       hsync_o;
    logic       vsync_o;
    logic [2:0] rgb_o;
    modport master (
        input  rgb_i,
        output column_o, row_o, video_on_o, frame_o, hsync_o, vsync_o, rgb_o
    );
    modport slave (
        output rgb_i,
        input  column_o, row_o, video_on_o, frame_o, hsync_o, vsync_o, rgb_o
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider, raster counters and one-pixel-late registered sync/colour pins.
module vga_sync_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input logic        clk,
    input logic        rst,
    vga_sync_if.master vga
);
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_ON  = H_VIS + H_FP;
    localparam int HS_OFF = HS_ON + H_SYNC;
    localparam int VS_ON  = V_VIS + V_FP;
    localparam int VS_OFF = VS_ON + V_SYNC;
    logic [4:0] div;
    logic [9:0] column;
    logic [9:0] row;
    logic       tick;
    logic       h_end;
    logic       v_end;
    logic       video_on;
    logic       hs_n;
    logic       vs_n;
    logic       frame;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;
    // 11-bit compares keep totals of exactly 1024 from aliasing to zero
    always_comb begin
        tick     = div == 5'(CLK_DIV - 1);
        h_end    = column == 10'(H_TOT - 1);
        v_end    = row == 10'(V_TOT - 1);
        video_on = {1'b0, column} < 11'(H_VIS) && {1'b0, row} < 11'(V_VIS);
        hs_n     = !({1'b0, column} >= 11'(HS_ON) && {1'b0, column} < 11'(HS_OFF));
        vs_n     = !({1'b0, row} >= 11'(VS_ON) && {1'b0, row} < 11'(VS_OFF));
    end
    // pins are decoded from the pre-edge position, so they trail column/row by one pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            column <= '0;
            row    <= '0;
            frame  <= 1'b0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            rgb    <= '0;
        end else begin
            div   <= tick ? '0 : div + 5'd1;
            frame <= tick && h_end && v_end;
            if (tick) begin
                column <= h_end ? '0 : column + 10'd1;
                if (h_end)
                    row <= v_end ? '0 : row + 10'd1;
                hsync <= hs_n;
                vsync <= vs_n;
                rgb   <= video_on ? vga.rgb_i : 3'b000;
            end
        end
    end
    assign vga.column_o   = column;
    assign vga.row_o      = row;
    assign vga.video_on_o = video_on;
    assign vga.frame_o    = frame;
    assign vga.hsync_o    = hsync;
    assign vga.vsync_o    = vsync;
    assign vga.rgb_o      = rgb;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of full-size line timing plus reduced-raster frame, reset and CLK_DIV=1 runs.
module tb_vga_sync_gen;
    typedef struct {
        int n;
        int col;
        int row;
        int von;
        int hs;
        int vs;
        int rgb;
    } vec_t;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int errors = 0;
    int checks = 0;
    vec_t tv[14];
    always #5 clk = ~clk;
    vga_sync_if ia();
    vga_sync_if ib();
    vga_sync_if ic();
    vga_sync_gen ua (.clk(clk), .rst(rst_a), .vga(ia));
    // small raster: H_TOT=24 (sync cols 18..20), V_TOT=15 (sync rows 10..11)
    vga_sync_gen #(.CLK_DIV(2), .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3))
        ub (.clk(clk), .rst(rst_b), .vga(ib));
    vga_sync_gen #(.CLK_DIV(1), .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3))
        uc (.clk(clk), .rst(rst_c), .vga(ic));
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_reset_b(input string tag);
        chk({tag, " col"}, int'(ib.column_o), 0);
        chk({tag, " row"}, int'(ib.row_o), 0);
        chk({tag, " video_on"}, int'(ib.video_on_o), 1);
        chk({tag, " frame"}, int'(ib.frame_o), 0);
        chk({tag, " hsync"}, int'(ib.hsync_o), 1);
        chk({tag, " vsync"}, int'(ib.vsync_o), 1);
        chk({tag, " rgb"}, int'(ib.rgb_o), 0);
    endtask
    initial begin
        int ea, eb, ec;
        int cnt_low, first_low, cnt_frame, frame_at, cnt_rgb, cnt_bad, cnt_vs;
        tv[0]  = '{0,    0,   0, 1, 1, 1, 0};
        tv[1]  = '{1,    0,   0, 1, 1, 1, 0};
        tv[2]  = '{2,    1,   0, 1, 1, 1, 5};
        tv[3]  = '{3,    1,   0, 1, 1, 1, 5};
        tv[4]  = '{1280, 640, 0, 0, 1, 1, 5};
        tv[5]  = '{1282, 641, 0, 0, 1, 1, 0};
        tv[6]  = '{1312, 656, 0, 0, 1, 1, 0};
        tv[7]  = '{1314, 657, 0, 0, 0, 1, 0};
        tv[8]  = '{1504, 752, 0, 0, 0, 1, 0};
        tv[9]  = '{1506, 753, 0, 0, 1, 1, 0};
        tv[10] = '{1596, 798, 0, 0, 1, 1, 0};
        tv[11] = '{1598, 799, 0, 0, 1, 1, 0};
        tv[12] = '{1600, 0,   1, 1, 1, 1, 0};
        tv[13] = '{1602, 1,   1, 1, 1, 1, 5};
        ia.rgb_i = 3'b101;
        ib.rgb_i = 3'b101;
        ic.rgb_i = 3'b101;
        repeat (3) @(negedge clk);
        chk("a reset frame", int'(ia.frame_o), 0);
        rst_a = 1'b0;
        ea = 0;
        for (int i = 0; i < 14; i++) begin
            while (ea < tv[i].n) begin
                @(negedge clk);
                ea++;
            end
            chk($sformatf("a n=%0d col", tv[i].n), int'(ia.column_o), tv[i].col);
            chk($sformatf("a n=%0d row", tv[i].n), int'(ia.row_o), tv[i].row);
            chk($sformatf("a n=%0d video_on", tv[i].n), int'(ia.video_on_o), tv[i].von);
            chk($sformatf("a n=%0d hsync", tv[i].n), int'(ia.hsync_o), tv[i].hs);
            chk($sformatf("a n=%0d vsync", tv[i].n), int'(ia.vsync_o), tv[i].vs);
            chk($sformatf("a n=%0d rgb", tv[i].n), int'(ia.rgb_o), tv[i].rgb);
        end
        cnt_low = 0;
        first_low = -1;
        while (ea < 3202) begin
            @(negedge clk);
            ea++;
            if (!ia.hsync_o) begin
                cnt_low++;
                if (first_low < 0) first_low = ea;
            end
        end
        chk("a hsync low clks", cnt_low, 192);
        chk("a hsync first low edge", first_low, 2914);
        rst_b = 1'b0;
        eb = 0;
        while (eb < 278) begin
            @(negedge clk);
            eb++;
        end
        chk("b pre-reset col", int'(ib.column_o), 19);
        chk("b pre-reset row", int'(ib.row_o), 5);
        chk("b pre-reset hsync", int'(ib.hsync_o), 0);
        rst_b = 1'b1;
        @(negedge clk);
        chk_reset_b("b midline reset");
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        cnt_frame = 0;
        frame_at = -1;
        cnt_vs = 0;
        first_low = -1;
        cnt_rgb = 0;
        cnt_bad = 0;
        for (int e = 1; e <= 721; e++) begin
            @(negedge clk);
            if (e == 1) chk("b release +1 col", int'(ib.column_o), 0);
            if (e == 2) chk("b release +2 col", int'(ib.column_o), 1);
            if (e == 719) begin
                chk("b pre-wrap col", int'(ib.column_o), 23);
                chk("b pre-wrap row", int'(ib.row_o), 14);
            end
            if (e == 720) begin
                chk("b wrap col", int'(ib.column_o), 0);
                chk("b wrap row", int'(ib.row_o), 0);
            end
            if (ib.frame_o) begin
                cnt_frame++;
                frame_at = e;
            end
            if (!ib.vsync_o) begin
                cnt_vs++;
                if (first_low < 0) first_low = e;
            end
            if (ib.rgb_o == 3'b101) cnt_rgb++;
            if (ib.rgb_o != 3'b000 && ib.row_o >= 10'd9) cnt_bad++;
        end
        chk("b frame pulses", cnt_frame, 1);
        chk("b frame edge", frame_at, 720);
        chk("b vsync low clks", cnt_vs, 96);
        chk("b vsync first low edge", first_low, 482);
        chk("b visible rgb clks", cnt_rgb, 256);
        chk("b blanked rows rgb", cnt_bad, 0);
        eb = 721;
        while (eb < 1439) begin
            @(negedge clk);
            eb++;
        end
        chk("b 2nd pre-wrap col", int'(ib.column_o), 23);
        chk("b 2nd pre-wrap row", int'(ib.row_o), 14);
        rst_b = 1'b1;
        @(negedge clk);
        chk_reset_b("b reset on wrap");
        @(negedge clk);
        chk("b reset on wrap frame hold", int'(ib.frame_o), 0);
        rst_b = 1'b0;
        rst_c = 1'b0;
        cnt_low = 0;
        cnt_vs = 0;
        cnt_frame = 0;
        frame_at = -1;
        ec = 0;
        for (int e = 1; e <= 12001; e++) begin
            @(negedge clk);
            ec = e;
            if (e == 1) chk("c +1 col", int'(ic.column_o), 1);
            if (e == 2) chk("c +2 col", int'(ic.column_o), 2);
            if (e == 799) begin
                chk("c 799 col", int'(ic.column_o), 799);
                chk("c 799 row", int'(ic.row_o), 0);
            end
            if (e == 800) begin
                chk("c 800 col", int'(ic.column_o), 0);
                chk("c 800 row", int'(ic.row_o), 1);
            end
            if (e <= 800 && !ic.hsync_o) cnt_low++;
            if (!ic.vsync_o) cnt_vs++;
            if (ic.frame_o) begin
                cnt_frame++;
                frame_at = e;
            end
        end
        chk("c hsync low clks", cnt_low, 96);
        chk("c vsync low clks", cnt_vs, 1600);
        chk("c frame pulses", cnt_frame, 1);
        chk("c frame edge", frame_at, 12000);
        chk("c edges run", ec, 12001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
